sram_bus_sampler: RTL and testbench
===================================

# sram_bus_sampler

Parametrised passive sampler for an asynchronous SRAM bus driven onto the GPIO header. Synchronises the bus strobes into the 200 MHz domain and qualifies read (and optionally write) cycles with a configurable settle window. Each qualified transaction becomes a timestamped record in an internal FIFO, drained over a valid/ready stream by downstream logic (SDRAM writer or UART dump). Successor to the single-read detector in the sample top level: generalised widths, write capture, back-to-back reads, buffering and overflow accounting.

## Interface
- ADDR_W, 15: SRAM address width.
- DATA_W, 8: SRAM data width.
- SETTLE, 4: consecutive synchronised cycles a strobe condition must hold before qualification; legal 1..15.
- FIFO_DEPTH, 16: record FIFO depth; power of two, ≥2.
- TS_W, 16: timestamp width.
- clk  in  1  200 MHz PLL clock.
- reset_n  in  1  synchronous, active-low reset.
- bus_e_n  in  1  SRAM chip enable, active low, asynchronous.
- bus_o_n  in  1  SRAM output enable, active low, asynchronous.
- bus_w_n  in  1  SRAM write enable, active low, asynchronous.
- bus_addr  in  ADDR_W  SRAM address pins, asynchronous.
- bus_data  in  DATA_W  SRAM data pins, asynchronous.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_kind  out  1  0 = read, 1 = write.
- rec_addr  out  ADDR_W  captured address.
- rec_data  out  DATA_W  captured data.
- rec_ts  out  TS_W  timestamp at capture.
- overflow_cnt  out  16  records dropped on full FIFO, saturating.
- act_toggle  out  1  toggles per accepted record (LED).

## Operation
- All bus inputs pass a 2-flop synchroniser; "synced" below refers to its output.
- rd_cond = !e_n & !o_n & w_n. wr_cond = !e_n & !w_n.
- FSM states: IDLE, RD_SETTLE, RD_HOLD, WR_SETTLE, WR_ACTIVE.
- IDLE: rd_cond → RD_SETTLE (settle count = 1); wr_cond → WR_SETTLE; wr_cond has priority.
- RD_SETTLE: count increments while rd_cond holds and address unchanged; on count reaching SETTLE, capture {0, addr, data, ts}, push, → RD_HOLD. Condition drop → IDLE, no record (glitch). Address change → restart count at 1.
- RD_HOLD: rd_cond false → IDLE. Address change while rd_cond holds → RD_SETTLE with count 1 (back-to-back reads yield one record each).
- WR_SETTLE: as RD_SETTLE on wr_cond (address change ignored); on SETTLE → WR_ACTIVE. Drop → IDLE.
- WR_ACTIVE: every cycle with wr_cond true, hold register latches addr, data, ts. First cycle wr_cond false: push {1, held values} → IDLE.
- ts: free-running TS_W counter, wraps 2^TS_W−1 → 0.
- FIFO full on push: record dropped, overflow_cnt += 1 saturating at 0xFFFF; push coinciding with a pop (rec_valid & rec_ready) while full is accepted.
- act_toggle inverts on every accepted push.

## Timing
- Reset (reset_n low at a clk edge): FSM IDLE, counters 0, FIFO empty, rec_valid 0, rec_kind/addr/data/ts 0, overflow_cnt 0, act_toggle 0, synchronisers 1 for strobes, 0 for addr/data. Reset mid-transaction discards it; no partial record.
- Pin change to synced: 2 cycles.
- Read: rd_cond first synced in cycle 0, held → push at edge ending cycle SETTLE−1; rec_valid high in cycle SETTLE if FIFO was empty.
- Write: push at edge ending first cycle with synced wr_cond false; rec_valid next cycle.
- rec_* stable while rec_valid & !rec_ready; pop on edge where both high; next record presented next cycle.

## Configuration
- SRAM_SAMPLER_WRITE_CAPTURE_EN defined: write path active as above.
- Undefined: WR_SETTLE/WR_ACTIVE not built, bus_w_n synchroniser removed, rd_cond = !e_n & !o_n, rec_kind constant 0.

## Structure
- sram_sampler_pkg: state encoding, KIND_READ/KIND_WRITE constants, record field width helpers.
- Sub-module sampler_fifo: synchronous FIFO (width 1+ADDR_W+DATA_W+TS_W, depth FIFO_DEPTH), show-ahead output, full/empty flags.

## Test plan
- Read addr 0x1234 data 0xA5, strobes low 10 cycles, SETTLE=4 → one record {0,0x1234,0xA5}, rec_valid in cycle 4 after synced assertion.
- Strobe low for 3 cycles, SETTLE=4 → no record, FSM back in IDLE.
- E/O held low, addr 0x0001→0x0002→0x0003 each held 6 cycles → three read records in order, ts strictly increasing.
- Write addr 0x7FFF, data 0x3C then 0x5A in last active cycle, W released → record {1,0x7FFF,0x5A}; without macro → no record.
- rec_ready low, 20 qualified reads with FIFO_DEPTH=16 → 16 records retained, overflow_cnt=4; simultaneous push/pop when full accepted.
- reset_n low during WR_ACTIVE → all outputs at reset values, no record after release.

Source files
------------

// File: rtl/sram_sampler_pkg.sv
// Shared types and helpers for the SRAM bus sampler: FSM encoding, record kinds, record width.
package sram_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETTLE = 3'd1,
    ST_RD_HOLD   = 3'd2,
    ST_WR_SETTLE = 3'd3,
    ST_WR_ACTIVE = 3'd4
  } state_e;

  localparam logic KIND_READ  = 1'b0;
  localparam logic KIND_WRITE = 1'b1;
  localparam int   OVF_W      = 16;

  // Record layout, MSB first: {kind, addr, data, ts}
  function automatic int rec_width(input int addr_w, input int data_w, input int ts_w);
    return 1 + addr_w + data_w + ts_w;
  endfunction

endpackage

// File: rtl/sampler_fifo.sv
// Synchronous show-ahead record FIFO; a push while full is taken only if a pop frees a slot that cycle.
module sampler_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             pop_s;
  logic             push_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);
  // Head reads as zero while empty so the record outputs show a clean value after reset
  assign head   = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_bus_sampler.sv
// Passive SRAM bus sampler: synchronises the bus, qualifies cycles, queues timestamped records.
// Define SRAM_SAMPLER_WRITE_CAPTURE_EN to also capture write cycles.
module sram_bus_sampler
  import sram_sampler_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int SETTLE     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bus_e_n,
  input  logic              bus_o_n,
  input  logic              bus_w_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic              rec_kind,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_data,
  output logic [TS_W-1:0]   rec_ts,
  output logic [OVF_W-1:0]  overflow_cnt,
  output logic              act_toggle
);

  localparam int         REC_W       = rec_width(ADDR_W, DATA_W, TS_W);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic       SETTLE_ONE  = (SETTLE == 1);

  logic [1:0]        e_sync_r, o_sync_r;
  logic [ADDR_W-1:0] addr_meta_r, addr_sync_r, addr_r;
  logic [DATA_W-1:0] data_meta_r, data_sync_r;
  logic [TS_W-1:0]   ts_r;
  state_e            state_r;
  logic [3:0]        cnt_r;
  logic              rd_cond_s, rd_start_s, rd_push_s, push_s, pop_s, drop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [REC_W-1:0]  push_rec_s, head_s;
  logic [OVF_W-1:0]  ovf_r;
  logic              tog_r;

  // Two-flop synchronisers; strobes idle high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_sync_r    <= 2'b11;
      o_sync_r    <= 2'b11;
      addr_meta_r <= '0;
      addr_sync_r <= '0;
      data_meta_r <= '0;
      data_sync_r <= '0;
    end else begin
      e_sync_r    <= {e_sync_r[0], bus_e_n};
      o_sync_r    <= {o_sync_r[0], bus_o_n};
      addr_meta_r <= bus_addr;
      addr_sync_r <= addr_meta_r;
      data_meta_r <= bus_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Free-running timestamp
  always_ff @(posedge clk) begin
    if (!reset_n) ts_r <= '0;
    else          ts_r <= ts_r + TS_W'(1);
  end

  // A read (re)starts from IDLE or on an address change during an ongoing read
  assign rd_start_s = rd_cond_s && ((state_r == ST_IDLE) ||
                      (((state_r == ST_RD_SETTLE) || (state_r == ST_RD_HOLD)) && (addr_sync_r != addr_r)));
  assign rd_push_s  = (rd_start_s && SETTLE_ONE) ||
                      (rd_cond_s && (state_r == ST_RD_SETTLE) && (addr_sync_r == addr_r) && (cnt_r == SETTLE_LAST));

`ifdef SRAM_SAMPLER_WRITE_CAPTURE_EN
  logic [1:0]                   w_sync_r;
  logic                         wr_cond_s, wr_qual_s, wr_push_s;
  logic [ADDR_W+DATA_W+TS_W-1:0] hold_r;

  assign rd_cond_s  = !e_sync_r[1] && !o_sync_r[1] && w_sync_r[1];
  assign wr_cond_s  = !e_sync_r[1] && !w_sync_r[1];
  assign wr_qual_s  = wr_cond_s && (((state_r == ST_IDLE) && SETTLE_ONE) ||
                      ((state_r == ST_WR_SETTLE) && (cnt_r == SETTLE_LAST)));
  assign wr_push_s  = (state_r == ST_WR_ACTIVE) && !wr_cond_s;
  assign push_s     = rd_push_s || wr_push_s;
  assign push_rec_s = wr_push_s ? {KIND_WRITE, hold_r} : {KIND_READ, addr_sync_r, data_sync_r, ts_r};
  assign rec_kind   = head_s[REC_W-1];

  // Write-enable synchroniser and write hold register (tracks the last active write cycle)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_sync_r <= 2'b11;
      hold_r   <= '0;
    end else begin
      w_sync_r <= {w_sync_r[0], bus_w_n};
      if (wr_cond_s) hold_r <= {addr_sync_r, data_sync_r, ts_r};
    end
  end
`else
  logic unused_w_s, unused_kind_s;

  assign unused_w_s    = bus_w_n;
  assign unused_kind_s = head_s[REC_W-1];
  assign rd_cond_s     = !e_sync_r[1] && !o_sync_r[1];
  assign push_s        = rd_push_s;
  assign push_rec_s    = {KIND_READ, addr_sync_r, data_sync_r, ts_r};
  assign rec_kind      = KIND_READ;
`endif

  // Transaction qualification FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
`ifdef SRAM_SAMPLER_WRITE_CAPTURE_EN
          if (wr_cond_s) begin
            cnt_r   <= 4'd1;
            state_r <= wr_qual_s ? ST_WR_ACTIVE : ST_WR_SETTLE;
          end else
`endif
          if (rd_start_s) begin
            cnt_r   <= 4'd1;
            addr_r  <= addr_sync_r;
            state_r <= rd_push_s ? ST_RD_HOLD : ST_RD_SETTLE;
          end
        end
        ST_RD_SETTLE, ST_RD_HOLD: begin
          if (!rd_cond_s) begin
            state_r <= ST_IDLE;
          end else if (rd_start_s) begin
            cnt_r   <= 4'd1;
            addr_r  <= addr_sync_r;
            state_r <= rd_push_s ? ST_RD_HOLD : ST_RD_SETTLE;
          end else if (rd_push_s) begin
            state_r <= ST_RD_HOLD;
          end else if (state_r == ST_RD_SETTLE) begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
`ifdef SRAM_SAMPLER_WRITE_CAPTURE_EN
        ST_WR_SETTLE: begin
          if (!wr_cond_s)     state_r <= ST_IDLE;
          else if (wr_qual_s) state_r <= ST_WR_ACTIVE;
          else                cnt_r   <= cnt_r + 4'd1;
        end
        ST_WR_ACTIVE: begin
          if (!wr_cond_s) state_r <= ST_IDLE;
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign pop_s  = rec_valid && rec_ready;
  assign drop_s = push_s && fifo_full_s && !pop_s;

  sampler_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign rec_valid    = !fifo_empty_s;
  assign rec_addr     = head_s[REC_W-2 -: ADDR_W];
  assign rec_data     = head_s[TS_W +: DATA_W];
  assign rec_ts       = head_s[TS_W-1:0];
  assign overflow_cnt = ovf_r;
  assign act_toggle   = tog_r;

  // Overflow accounting and activity toggle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_r <= '0;
      tog_r <= 1'b0;
    end else begin
      if (drop_s && (ovf_r != 16'hFFFF)) ovf_r <= ovf_r + 16'd1;
      if (push_s && !drop_s)             tog_r <= !tog_r;
    end
  end

endmodule

// File: tb/tb_sram_bus_sampler.sv
// Directed self-checking bench for sram_bus_sampler (default parameters, SETTLE=4, FIFO_DEPTH=16).
`timescale 1ns/100ps
module tb_sram_bus_sampler;

  logic        clk = 1'b0;
  logic        reset_n, bus_e_n, bus_o_n, bus_w_n, rec_ready;
  logic [14:0] bus_addr;
  logic [7:0]  bus_data;
  logic        rec_valid, rec_kind, act_toggle;
  logic [14:0] rec_addr;
  logic [7:0]  rec_data;
  logic [15:0] rec_ts, overflow_cnt;
  int          errors = 0;
  int          checks = 0;
  logic        exp_toggle = 1'b0;

  always #2.5 clk = ~clk;

  sram_bus_sampler dut (
    .clk(clk), .reset_n(reset_n), .bus_e_n(bus_e_n), .bus_o_n(bus_o_n), .bus_w_n(bus_w_n),
    .bus_addr(bus_addr), .bus_data(bus_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_addr(rec_addr), .rec_data(rec_data), .rec_ts(rec_ts),
    .overflow_cnt(overflow_cnt), .act_toggle(act_toggle)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_e_n = 1'b1; bus_o_n = 1'b1; bus_w_n = 1'b1;
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    @(posedge clk);
    #1;
    rec_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rec_ready = 1'b0; bus_addr = 15'h0; bus_data = 8'h0;
    bus_idle();
    tick(3);
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
    checks++; if (rec_kind !== 1'b0) begin errors++; $display("FAIL reset_kind: got %b want 0", rec_kind); end
    checks++; if (rec_addr !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", rec_addr); end
    checks++; if (rec_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rec_data); end
    checks++; if (rec_ts !== 16'h0) begin errors++; $display("FAIL reset_ts: got %h want 0", rec_ts); end
    checks++; if (overflow_cnt !== 16'h0) begin errors++; $display("FAIL reset_ovf: got %h want 0", overflow_cnt); end
    checks++; if (act_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b want 0", act_toggle); end
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic test_read();
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0; bus_w_n = 1'b1; bus_addr = 15'h1234; bus_data = 8'hA5;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 5) begin checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL read_early: got %b want 0", rec_valid); end end
      if (i == 6) begin checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL read_latency: got %b want 1", rec_valid); end end
    end
    checks++; if (rec_kind !== 1'b0) begin errors++; $display("FAIL read_kind: got %b want 0", rec_kind); end
    checks++; if (rec_addr !== 15'h1234) begin errors++; $display("FAIL read_addr: got %h want 1234", rec_addr); end
    checks++; if (rec_data !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", rec_data); end
    tick(4);
    bus_idle();
    tick(6);
    pop_one();
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL read_single: got %b want 0", rec_valid); end
    exp_toggle = ~exp_toggle;
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL read_toggle: got %b want %b", act_toggle, exp_toggle); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0; bus_addr = 15'h0042;
    tick(3);
    bus_idle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rec_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_record: got %b want 0", seen); end
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL glitch_toggle: got %b want %b", act_toggle, exp_toggle); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ts_prev;
    logic [14:0] exp_addr;
    logic [7:0]  exp_data;
    ts_prev = 16'h0;
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus_addr = 15'(k);
      bus_data = 8'(k * 17);
      tick(6);
    end
    bus_idle();
    tick(4);
    for (int k = 1; k <= 3; k++) begin
      exp_addr = 15'(k);
      exp_data = 8'(k * 17);
      @(negedge clk);
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", k, rec_valid); end
      checks++; if (rec_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", k, rec_addr, exp_addr); end
      checks++; if (rec_data !== exp_data) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, rec_data, exp_data); end
      if (k > 1) begin
        checks++; if ((rec_ts - ts_prev) !== 16'd6) begin errors++; $display("FAIL b2b_ts%0d: got delta %0d want 6", k, rec_ts - ts_prev); end
      end
      ts_prev = rec_ts;
      pop_one();
      exp_toggle = ~exp_toggle;
    end
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL b2b_count: got %b want 0", rec_valid); end
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL b2b_toggle: got %b want %b", act_toggle, exp_toggle); end
  endtask

  task automatic test_write();
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b1; bus_w_n = 1'b0; bus_addr = 15'h7FFF; bus_data = 8'h3C;
    tick(8);
    bus_data = 8'h5A;
    tick(1);
    bus_idle();
    tick(2);
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL write_early: got %b want 0", rec_valid); end
    tick(1);
    @(negedge clk);
`ifdef SRAM_SAMPLER_WRITE_CAPTURE_EN
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL write_valid: got %b want 1", rec_valid); end
    checks++; if (rec_kind !== 1'b1) begin errors++; $display("FAIL write_kind: got %b want 1", rec_kind); end
    checks++; if (rec_addr !== 15'h7FFF) begin errors++; $display("FAIL write_addr: got %h want 7fff", rec_addr); end
    checks++; if (rec_data !== 8'h5A) begin errors++; $display("FAIL write_data: got %h want 5a", rec_data); end
    pop_one();
    exp_toggle = ~exp_toggle;
`else
    tick(6);
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL write_ignored: got %b want 0", rec_valid); end
`endif
    @(negedge clk);
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL write_toggle: got %b want %b", act_toggle, exp_toggle); end
  endtask

  task automatic test_overflow();
    logic [14:0] exp_addr;
    logic [7:0]  exp_data;
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0;
    for (int j = 0; j < 20; j++) begin
      bus_addr = 15'h100 + 15'(j);
      bus_data = 8'(j);
      tick(6);
    end
    bus_idle();
    tick(4);
    for (int j = 0; j < 16; j++) exp_toggle = ~exp_toggle;
    @(negedge clk);
    checks++; if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", overflow_cnt); end
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL ovf_toggle: got %b want %b", act_toggle, exp_toggle); end
    // push coinciding with a pop while full
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0; bus_addr = 15'h200; bus_data = 8'h77;
    tick(5);
    @(negedge clk);
    rec_ready = 1'b1;
    @(posedge clk);
    #1;
    rec_ready = 1'b0;
    exp_toggle = ~exp_toggle;
    tick(2);
    bus_idle();
    tick(4);
    @(negedge clk);
    checks++; if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL ovf_pushpop: got %0d want 4", overflow_cnt); end
    for (int j = 1; j <= 16; j++) begin
      exp_addr = (j == 16) ? 15'h200 : 15'h100 + 15'(j);
      exp_data = (j == 16) ? 8'h77 : 8'(j);
      @(negedge clk);
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL drain_valid%0d: got %b want 1", j, rec_valid); end
      checks++; if (rec_addr !== exp_addr) begin errors++; $display("FAIL drain_addr%0d: got %h want %h", j, rec_addr, exp_addr); end
      checks++; if (rec_data !== exp_data) begin errors++; $display("FAIL drain_data%0d: got %h want %h", j, rec_data, exp_data); end
      pop_one();
    end
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", rec_valid); end
    checks++; if (act_toggle !== exp_toggle) begin errors++; $display("FAIL drain_toggle: got %b want %b", act_toggle, exp_toggle); end
  endtask

  task automatic test_reset_mid();
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b0; bus_addr = 15'h0055; bus_data = 8'h66;
    tick(6);
    bus_idle();
    tick(4);
    @(negedge clk);
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", rec_valid); end
    tick(1);
    bus_e_n = 1'b0; bus_o_n = 1'b1; bus_w_n = 1'b0; bus_addr = 15'h7FFF; bus_data = 8'h3C;
    tick(8);
    reset_n = 1'b0;
    tick(1);
    bus_idle();
    tick(2);
    @(negedge clk);
    exp_toggle = 1'b0;
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", rec_valid); end
    checks++; if (rec_kind !== 1'b0) begin errors++; $display("FAIL mid_kind: got %b want 0", rec_kind); end
    checks++; if (rec_addr !== 15'h0) begin errors++; $display("FAIL mid_addr: got %h want 0", rec_addr); end
    checks++; if (rec_data !== 8'h0) begin errors++; $display("FAIL mid_data: got %h want 0", rec_data); end
    checks++; if (rec_ts !== 16'h0) begin errors++; $display("FAIL mid_ts: got %h want 0", rec_ts); end
    checks++; if (overflow_cnt !== 16'h0) begin errors++; $display("FAIL mid_ovf: got %0d want 0", overflow_cnt); end
    checks++; if (act_toggle !== 1'b0) begin errors++; $display("FAIL mid_toggle: got %b want 0", act_toggle); end
    tick(1);
    reset_n = 1'b1;
    tick(12);
    @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL mid_norecord: got %b want 0", rec_valid); end
    checks++; if (act_toggle !== 1'b0) begin errors++; $display("FAIL mid_toggle_after: got %b want 0", act_toggle); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_glitch();
    test_back_to_back();
    test_write();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
